vga_axi_lite_write_master: RTL and testbench

AXI4-Lite write-channel initiator for the VGA Controller memory bus. It is the write-side counterpart of the existing read master. It accepts single-beat write requests from a local client, such as a frame-buffer fill engine or a CPU bridge. For each request it drives the AW, W and B channels to a memory slave and reports completion and response status back to the client. One transaction is outstanding at a time.

---
 rtl/vga_axi_lite_write_master.sv | 183 ++++++++++++++++++
 tb/tb_vga_axi_lite_write_master.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_axi_lite_write_master.sv
// ---------------------------------------------------------------------------
// vga_axi_lite_write_master
//
// Purpose: AXI4-Lite write-channel initiator for the VGA controller memory
// bus. It accepts single-beat write requests from a local client, such as a
// frame-buffer fill engine or a CPU bridge. For each request it drives the
// AW, W and B channels and reports completion and response status back to
// the client. Only one transaction is outstanding at a time.
//
// Ports:
//   m_aclk_i, m_arst_i       clock (rising edge), synchronous active-high reset
//   wr_req_i                 client request, sampled only while wr_rdy_o=1
//   wr_addr_i/data_i/strb_i  client byte address, data and byte enables
//   wr_rdy_o                 idle, able to accept a request
//   wr_done_o / wr_err_o     one-cycle completion pulse / error pulse
//                            (SLVERR or DECERR)
//   wr_resp_o                last captured BRESP, held until next completion
//   wr_cnt_o                 completed-write counter (wraps)
//   m_aw*                    AXI write address channel
//   m_w*                     AXI write data channel
//   m_b*                     AXI write response channel
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. Once raised, this master holds a valid, and the
// payload behind it, unchanged until that transfer. Ready may arrive before
// valid. On the client side, a request is taken on any edge where wr_req_i
// and wr_rdy_o are both high.
// ---------------------------------------------------------------------------
module vga_axi_lite_write_master #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter logic [2:0]  AXI_PROT       = 3'b000,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                          m_aclk_i,
  input  logic                          m_arst_i,
  // client side
  input  logic                          wr_req_i,
  input  logic [AXI_ADDR_WIDTH-1:0]     wr_addr_i,
  input  logic [AXI_DATA_WIDTH-1:0]     wr_data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0]   wr_strb_i,
  output logic                          wr_rdy_o,
  output logic                          wr_done_o,
  output logic                          wr_err_o,
  output logic [1:0]                    wr_resp_o,
  output logic [CNT_WIDTH-1:0]          wr_cnt_o,
  // AXI write address channel
  output logic [AXI_ADDR_WIDTH-1:0]     m_awaddr_o,
  output logic [2:0]                    m_awprot_o,
  output logic                          m_awvalid_o,
  input  logic                          m_awrdy_i,
  // AXI write data channel
  output logic [AXI_DATA_WIDTH-1:0]     m_wdata_o,
  output logic [AXI_DATA_WIDTH/8-1:0]   m_wstrb_o,
  output logic                          m_wvalid_o,
  input  logic                          m_wrdy_i,
  // AXI write response channel
  input  logic [1:0]                    m_bresp_i,
  input  logic                          m_bvalid_i,
  output logic                          m_brdy_o
);

  localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;
  localparam int unsigned LSB_BITS   = $clog2(STRB_WIDTH);
  // Byte-offset bits inside one bus word; forced to zero on the address.
  localparam logic [AXI_ADDR_WIDTH-1:0] LOW_MASK =
    AXI_ADDR_WIDTH'((1 << LSB_BITS) - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                       state_q, state_d;
  logic                         awvalid_q, awvalid_d;
  logic                         wvalid_q, wvalid_d;
  logic [AXI_ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0]    data_q, data_d;
  logic [STRB_WIDTH-1:0]        strb_q, strb_d;
  logic                         done_q, done_d;
  logic                         err_q, err_d;
  logic [1:0]                   resp_q, resp_d;
  logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;

  logic aw_hs;
  logic w_hs;
  logic aw_finished;
  logic w_finished;

  assign aw_hs = awvalid_q & m_awrdy_i;
  assign w_hs  = wvalid_q & m_wrdy_i;
  // A channel is finished once its valid has dropped or is transferring now,
  // so AW and W may complete in either order or on the same edge.
  assign aw_finished = ~awvalid_q | aw_hs;
  assign w_finished  = ~wvalid_q | w_hs;

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    addr_d    = addr_q;
    data_d    = data_q;
    strb_d    = strb_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    resp_d    = resp_q;
    cnt_d     = cnt_q;

    case (state_q)
      IDLE: begin
        if (wr_req_i) begin
          addr_d    = wr_addr_i & ~LOW_MASK;
          data_d    = wr_data_i;
          strb_d    = wr_strb_i;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if (aw_finished && w_finished) state_d = RESP;
      end
      RESP: begin
        if (m_bvalid_i) begin
          resp_d  = m_bresp_i;
          cnt_d   = cnt_q + 1'b1;
          done_d  = 1'b1;
          // SLVERR and DECERR both have bit 1 set; OKAY/EXOKAY are success.
          err_d   = m_bresp_i[1];
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge m_aclk_i) begin
    if (m_arst_i) begin
      state_q   <= IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      resp_q    <= 2'b00;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
      done_q    <= done_d;
      err_q     <= err_d;
      resp_q    <= resp_d;
      cnt_q     <= cnt_d;
    end
  end

  assign wr_rdy_o    = (state_q == IDLE);
  assign m_brdy_o    = (state_q == RESP);
  assign wr_done_o   = done_q;
  assign wr_err_o    = err_q;
  assign wr_resp_o   = resp_q;
  assign wr_cnt_o    = cnt_q;
  assign m_awaddr_o  = addr_q;
  assign m_awprot_o  = AXI_PROT;
  assign m_awvalid_o = awvalid_q;
  assign m_wdata_o   = data_q;
  assign m_wstrb_o   = strb_q;
  assign m_wvalid_o  = wvalid_q;

endmodule

// File: tb/tb_vga_axi_lite_write_master.sv
// ---------------------------------------------------------------------------
// tb_vga_axi_lite_write_master
//
// Self-checking bench for vga_axi_lite_write_master (64-bit data, 4-bit
// counter). The reference model is transaction level. Each accepted request
// pushes {aligned addr, data, strb, bresp} plus a predicted completion
// latency. The latency is predicted from the slave wait settings:
//   send cycles = max(aw_wait, w_wait) + 1
//   resp cycles = early_b ? 1 : b_wait + 1
// A slave model answers the AXI channels and checks the payload against the
// head of the queue.
// ---------------------------------------------------------------------------
module tb_vga_axi_lite_write_master;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = DW / 8;
  localparam int CW = 4;
  localparam int EW = AW + DW + SW + 2;

  logic          m_aclk_i = 1'b0;
  logic          m_arst_i = 1'b1;
  logic          wr_req_i = 1'b0;
  logic [AW-1:0] wr_addr_i = '0;
  logic [DW-1:0] wr_data_i = '0;
  logic [SW-1:0] wr_strb_i = '0;
  logic          wr_rdy_o, wr_done_o, wr_err_o;
  logic [1:0]    wr_resp_o;
  logic [CW-1:0] wr_cnt_o;
  logic [AW-1:0] m_awaddr_o;
  logic [2:0]    m_awprot_o;
  logic          m_awvalid_o;
  logic          m_awrdy_i = 1'b0;
  logic [DW-1:0] m_wdata_o;
  logic [SW-1:0] m_wstrb_o;
  logic          m_wvalid_o;
  logic          m_wrdy_i = 1'b0;
  logic [1:0]    m_bresp_i = 2'b00;
  logic          m_bvalid_i = 1'b0;
  logic          m_brdy_o;

  vga_axi_lite_write_master #(
    .AXI_ADDR_WIDTH (AW),
    .AXI_DATA_WIDTH (DW),
    .AXI_PROT       (3'b000),
    .CNT_WIDTH      (CW)
  ) dut (
    .m_aclk_i    (m_aclk_i),
    .m_arst_i    (m_arst_i),
    .wr_req_i    (wr_req_i),
    .wr_addr_i   (wr_addr_i),
    .wr_data_i   (wr_data_i),
    .wr_strb_i   (wr_strb_i),
    .wr_rdy_o    (wr_rdy_o),
    .wr_done_o   (wr_done_o),
    .wr_err_o    (wr_err_o),
    .wr_resp_o   (wr_resp_o),
    .wr_cnt_o    (wr_cnt_o),
    .m_awaddr_o  (m_awaddr_o),
    .m_awprot_o  (m_awprot_o),
    .m_awvalid_o (m_awvalid_o),
    .m_awrdy_i   (m_awrdy_i),
    .m_wdata_o   (m_wdata_o),
    .m_wstrb_o   (m_wstrb_o),
    .m_wvalid_o  (m_wvalid_o),
    .m_wrdy_i    (m_wrdy_i),
    .m_bresp_i   (m_bresp_i),
    .m_bvalid_i  (m_bvalid_i),
    .m_brdy_o    (m_brdy_o)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 m_aclk_i = ~m_aclk_i;

  int cyc = 0;
  always @(posedge m_aclk_i) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model state ----------------
  logic [EW-1:0] exp_q[$];
  int            lat_q[$];
  int            acc_q[$];
  bit            busy = 1'b0;
  int            model_cnt = 0;
  int            done_count = 0;

  // slave behaviour knobs (fixed for the lifetime of one transaction)
  int aw_wait = 0, w_wait = 0, b_wait = 1;
  bit early_b = 1'b0;
  int aw_seen = 0, w_seen = 0, b_seen = 0, aw_cyc = 0, w_cyc = 0;

  logic [EW-1:0] mon_e;
  int            mon_lat, mon_acc;

  function automatic int pred_lat(input int aw, input int w, input int b, input bit eb);
    int s;
    s = (aw > w) ? aw : w;
    return s + 1 + (eb ? 1 : b + 1);
  endfunction

  task automatic push_txn(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, input logic [1:0] r, input int lat);
    exp_q.push_back({a & ~32'h7, d, s, r});
    lat_q.push_back(lat);
    acc_q.push_back(cyc);
    busy = 1'b1;
  endtask

  // ---------------- monitor + slave model (negedge) ----------------
  initial begin
    forever begin
      @(negedge m_aclk_i);
      // completion scoreboard
      if (wr_done_o) begin
        done_count++;
        if (exp_q.size() == 0) begin
          chk("spurious_done", 1'b1, 1'b0);
        end else begin
          mon_e   = exp_q.pop_front();
          mon_lat = lat_q.pop_front();
          mon_acc = acc_q.pop_front();
          model_cnt = (model_cnt + 1) % (1 << CW);
          chk("resp", wr_resp_o, mon_e[1:0]);
          chk("err", wr_err_o, mon_e[1]);
          chk("cnt", wr_cnt_o, model_cnt);
          chk("latency", cyc - mon_acc, mon_lat);
          busy = 1'b0;
        end
      end else begin
        chk("err_without_done", wr_err_o, 1'b0);
      end
      chk("rdy", wr_rdy_o, !busy);
      chk("brdy_before_hs", m_brdy_o && (m_awvalid_o || m_wvalid_o), 1'b0);

      // AW channel
      if (m_awvalid_o) begin
        if (exp_q.size() == 0) chk("aw_unexpected", 1'b1, 1'b0);
        else begin
          mon_e = exp_q[0];
          chk("awaddr", m_awaddr_o, mon_e[EW-1 -: AW]);
        end
        chk("awprot", m_awprot_o, 3'b000);
        aw_cyc++;
        m_awrdy_i = (aw_seen >= aw_wait);
        aw_seen++;
      end else begin
        if (aw_cyc != 0) chk("aw_valid_len", aw_cyc, aw_wait + 1);
        aw_cyc = 0;
        aw_seen = 0;
        m_awrdy_i = (aw_wait == 0);
      end

      // W channel
      if (m_wvalid_o) begin
        if (exp_q.size() == 0) chk("w_unexpected", 1'b1, 1'b0);
        else begin
          mon_e = exp_q[0];
          chk("wdata", m_wdata_o, mon_e[EW-1-AW -: DW]);
          chk("wstrb", m_wstrb_o, mon_e[SW+1:2]);
        end
        w_cyc++;
        m_wrdy_i = (w_seen >= w_wait);
        w_seen++;
      end else begin
        if (w_cyc != 0) chk("w_valid_len", w_cyc, w_wait + 1);
        w_cyc = 0;
        w_seen = 0;
        m_wrdy_i = (w_wait == 0);
      end

      // B channel; BRESP=11 while not accepted would show up as a bogus error
      if (m_brdy_o) begin
        m_bvalid_i = early_b || (b_seen >= b_wait);
        b_seen++;
        if (m_bvalid_i && exp_q.size() != 0) begin
          mon_e = exp_q[0];
          m_bresp_i = mon_e[1:0];
        end else begin
          m_bresp_i = 2'b11;
        end
      end else begin
        b_seen = 0;
        m_bvalid_i = early_b && (m_awvalid_o || m_wvalid_o);
        m_bresp_i = 2'b11;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(negedge m_aclk_i);
      n++;
    end
    if (busy) begin
      chk("idle_timeout", 1'b1, 1'b0);
      exp_q.delete(); lat_q.delete(); acc_q.delete();
      busy = 1'b0;
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, input logic [1:0] r,
                          input int aw, input int w, input int b, input bit eb);
    wait_idle();
    @(negedge m_aclk_i);
    aw_wait = aw; w_wait = w; b_wait = b; early_b = eb;
    wr_req_i = 1'b1; wr_addr_i = a; wr_data_i = d; wr_strb_i = s;
    @(posedge m_aclk_i);
    #1;
    push_txn(a, d, s, r, pred_lat(aw, w, b, eb));
    wr_req_i = 1'b0;
    wr_addr_i = $urandom;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_awvalid"}, m_awvalid_o, 1'b0);
    chk({tag, "_wvalid"}, m_wvalid_o, 1'b0);
    chk({tag, "_brdy"}, m_brdy_o, 1'b0);
    chk({tag, "_done"}, wr_done_o, 1'b0);
    chk({tag, "_rdy"}, wr_rdy_o, 1'b1);
    chk({tag, "_cnt"}, wr_cnt_o, 4'd0);
    chk({tag, "_resp"}, wr_resp_o, 2'b00);
    chk({tag, "_awaddr"}, m_awaddr_o, 32'h0);
    chk({tag, "_wdata"}, m_wdata_o, 64'h0);
  endtask

  // ---------------- test sequence ----------------
  logic [AW-1:0] ra;
  logic [DW-1:0] rd;
  logic [SW-1:0] rs;
  logic [1:0]    rr;
  int            start_done;

  initial begin
    // reset
    m_arst_i = 1'b1;
    repeat (3) @(posedge m_aclk_i);
    @(negedge m_aclk_i);
    check_reset_outputs("reset");
    m_arst_i = 1'b0;

    // zero-wait slave, unaligned address
    do_write(32'h0000_1003, 64'hDEADBEEF_CAFEF00D, 8'hFF, 2'b00, 0, 0, 1, 1'b0);
    // AW ready late (valid held 5 cycles), W immediate
    do_write(32'h0000_2011, 64'h0123_4567_89AB_CDEF, 8'h0F, 2'b00, 4, 0, 1, 1'b0);
    // W ready late, early bvalid during SEND, EXOKAY
    do_write(32'h0000_3FFF, 64'h1111_2222_3333_4444, 8'hA5, 2'b01, 0, 3, 1, 1'b1);
    // SLVERR then DECERR back to back
    do_write(32'h0000_4000, 64'h5555_6666_7777_8888, 8'h3C, 2'b10, 0, 0, 0, 1'b0);
    do_write(32'h0000_4008, 64'h9999_AAAA_BBBB_CCCC, 8'hC3, 2'b11, 1, 1, 2, 1'b0);
    wait_idle();

    // randomized traffic
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rd = {$urandom, $urandom};
      rs = 8'($urandom_range(0, 255));
      rr = 2'($urandom_range(0, 3));
      do_write(ra, rd, rs, rr, $urandom_range(0, 4), $urandom_range(0, 4),
               $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    wait_idle();

    // reset while AW is pending in SEND
    do_write(32'h0000_5005, 64'hFEED_FACE_0BAD_F00D, 8'hFF, 2'b00, 10, 0, 1, 1'b0);
    repeat (2) @(negedge m_aclk_i);
    m_arst_i = 1'b1;
    @(posedge m_aclk_i);
    #1;
    exp_q.delete(); lat_q.delete(); acc_q.delete();
    busy = 1'b0; model_cnt = 0; aw_cyc = 0; aw_seen = 0; w_cyc = 0; w_seen = 0;
    @(negedge m_aclk_i);
    m_arst_i = 1'b0;
    check_reset_outputs("midreset");

    // request held high for 100 cycles with a zero-wait slave
    start_done = done_count;
    aw_wait = 0; w_wait = 0; b_wait = 1; early_b = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge m_aclk_i);
      wr_req_i  = 1'b1;
      wr_addr_i = $urandom;
      wr_data_i = {$urandom, $urandom};
      wr_strb_i = 8'($urandom_range(0, 255));
      @(posedge m_aclk_i);
      #1;
      if (!busy) push_txn(wr_addr_i, wr_data_i, wr_strb_i, 2'b00, pred_lat(0, 0, 1, 1'b0));
    end
    wr_req_i = 1'b0;
    wait_idle();
    @(negedge m_aclk_i);
    chk("stream_completions", done_count - start_done, 25);
    chk("stream_cnt_wrap", wr_cnt_o, 4'd9);

    repeat (4) @(negedge m_aclk_i);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // hard stop in case the sequence itself wedges
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
